// File: rtl/tlm_get_arbiter.sv
// ---------------------------------------------------------------------------
// tlm_get_arbiter
//
// Purpose:
//   Shares one get-style item provider (i_src_valid = can_get,
//   o_src_pop = get) among NUM_REQ requesters. Each requester issues a
//   blocking get or a nonblocking try_get. Winners are chosen round-robin and
//   a blocking get may give up after MAX_WAIT cycles without data. Only one
//   get is in flight at a time.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_req        per-requester request level, held until done or abort
//   i_nb         per-requester 1 = try_get, 0 = blocking get (sampled at grant)
//   o_done       one-cycle completion pulse for the served requester
//   o_ok         qualifies o_done: 1 = item delivered, 0 = try fail / timeout
//   o_rdata      last delivered item, held until the next delivery
//   i_src_valid  provider holds an item
//   i_src_data   provider item
//   o_src_pop    consume the provider item this cycle (combinational)
//   o_busy       arbiter is serving a get
// ---------------------------------------------------------------------------
module tlm_get_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_nb,
    output logic [NUM_REQ-1:0] o_done,
    output logic [NUM_REQ-1:0] o_ok,
    output logic [DATA_W-1:0]  o_rdata,
    input  logic               i_src_valid,
    input  logic [DATA_W-1:0]  i_src_data,
    output logic               o_src_pop,
    output logic               o_busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // A zero MAX_WAIT still needs a one-bit counter so the design elaborates.
    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_RESP
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_idx;
    logic               r_nb;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] r_done;
    logic [NUM_REQ-1:0] r_ok;
    logic [DATA_W-1:0]  r_rdata;

    logic               w_found;
    logic [IDX_W-1:0]   w_winner;
    logic [IDX_W-1:0]   w_cand;
    logic               w_timeout;

    // Round-robin search: first active request starting at r_ptr, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // Last allowed waiting cycle of a blocking get; never true when MAX_WAIT = 0.
    assign w_timeout = (MAX_WAIT != 0) && (r_cnt == CNT_LAST);

    // Pop only while the granted requester still wants the item, so an abort
    // in the same cycle leaves the provider untouched.
    assign o_src_pop = (r_state == S_GRANT) && i_src_valid && i_req[r_idx];
    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = r_done;
    assign o_ok      = r_ok;
    assign o_rdata   = r_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_nb    <= 1'b0;
            r_cnt   <= '0;
            r_done  <= '0;
            r_ok    <= '0;
            r_rdata <= '0;
        end else begin
            // done/ok are single-cycle pulses, raised only on the way into RESP.
            r_done <= '0;
            r_ok   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_idx   <= w_winner;
                        r_nb    <= i_nb[w_winner];
                        r_cnt   <= '0;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (!i_req[r_idx]) begin
                        r_state <= S_IDLE;
                    end else if (i_src_valid) begin
                        r_rdata       <= i_src_data;
                        r_done[r_idx] <= 1'b1;
                        r_ok[r_idx]   <= 1'b1;
                        r_state       <= S_RESP;
                    end else if (r_nb || w_timeout) begin
                        r_done[r_idx] <= 1'b1;
                        r_state       <= S_RESP;
                    end else if (MAX_WAIT != 0) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    // Failures advance the pointer too, so nobody hogs the provider.
                    r_ptr   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
